// File: rtl/dec138_rr_arbiter_if.sv
// Bus between the requesters and the arbiter that drives a shared 74LS138-style decoder.
// The arbiter uses the slave modport and the request side uses the master modport.
interface dec138_rr_arbiter_if;
  logic [7:0] req;
  logic       C;
  logic       B;
  logic       A;
  logic       G;
  logic       G2A;
  logic       G2B;
  logic [7:0] Y;
  logic       busy;

  modport master (output req, input C, B, A, G, G2A, G2B, Y, busy);
  modport slave  (input req, output C, B, A, G, G2A, G2B, Y, busy);
endinterface

// File: rtl/dec138_rr_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoder, with break-before-make gaps.
// Define ARB_FIXED_PRIO_EN to get fixed lowest-index-wins priority instead of round-robin.
module dec138_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  dec138_rr_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [7:0] y_q, y_d;
  logic       en_q, en_d;
  logic [2:0] win;
  logic [2:0] scan;
  logic       others;

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    win  = '0;
    scan = '0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.req[i]) win = 3'(i);
    end
  end
`else
  // Walk offsets 8 down to 1 so the smallest offset past last_q is assigned last and wins;
  // offset 8 wraps to last_q itself, so a lone previous winner can still re-win.
  always_comb begin
    win  = '0;
    scan = '0;
    for (int i = 8; i >= 1; i--) begin
      scan = last_q + 3'(i);
      if (bus.req[scan]) win = scan;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    hold_d  = hold_q;
    others  = |(bus.req & ~(8'h01 << idx_q));
    unique case (state_q)
      IDLE, GAP: begin
        if (|bus.req) begin
          state_d = GRANT;
          idx_d   = win;
          last_d  = win;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[idx_q] || ((hold_q == HoldMax) && others)) begin
          state_d = GAP;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops already aligned with it.
  always_comb begin
    en_d = (state_d == GRANT);
    y_d  = en_d ? ~(8'h01 << idx_d) : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      last_q  <= 3'd7;
      hold_q  <= 4'd0;
      y_q     <= 8'hFF;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      en_q    <= en_d;
    end
  end

  assign bus.C    = idx_q[2];
  assign bus.B    = idx_q[1];
  assign bus.A    = idx_q[0];
  assign bus.G    = en_q;
  assign bus.G2A  = ~en_q;
  assign bus.G2B  = ~en_q;
  assign bus.Y    = y_q;
  assign bus.busy = en_q;

endmodule

// File: tb/tb_dec138_rr_arbiter.sv
// Directed self-checking bench for dec138_rr_arbiter (MAX_HOLD = 4).
// Expectations follow ARB_FIXED_PRIO_EN when the bench is built with it defined.
module tb_dec138_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dec138_rr_arbiter_if bus ();

  dec138_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    tick();
    tick();
    checks++;
    if (bus.Y !== 8'hFF) begin
      errors++;
      $display("FAIL reset_y: got %h want ff", bus.Y);
    end
    checks++;
    if ({bus.G, bus.G2A, bus.G2B} !== 3'b011) begin
      errors++;
      $display("FAIL reset_en: got %b want 011", {bus.G, bus.G2A, bus.G2B});
    end
    checks++;
    if ({bus.busy, bus.C, bus.B, bus.A} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sel_busy: got %b want 0000", {bus.busy, bus.C, bus.B, bus.A});
    end
    rst_n   = 1'b1;
    bus.req = 8'h00;
  endtask

  task automatic test_single();
    apply_reset();
    bus.req = 8'h04;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 3) bus.req = 8'h00;
      checks++;
      if ({bus.Y, bus.C, bus.B, bus.A, bus.busy} !== {8'hFB, 3'b010, 1'b1}) begin
        errors++;
        $display("FAIL single_grant c%0d: got y=%h sel=%b busy=%b want y=fb sel=010 busy=1",
                 c, bus.Y, {bus.C, bus.B, bus.A}, bus.busy);
      end
    end
    tick();
    checks++;
    if ({bus.Y, bus.C, bus.B, bus.A, bus.busy, bus.G} !== {8'hFF, 3'b010, 2'b00}) begin
      errors++;
      $display("FAIL single_gap: got y=%h sel=%b busy=%b g=%b want y=ff sel=010 busy=0 g=0",
               bus.Y, {bus.C, bus.B, bus.A}, bus.busy, bus.G);
    end
    tick();
    checks++;
    if ({bus.Y, bus.busy} !== {8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL single_idle: got y=%h busy=%b want y=ff busy=0", bus.Y, bus.busy);
    end
  endtask

  task automatic test_two();
    logic [7:0] exp;
    int pos;
    apply_reset();
    bus.req = 8'h81;
    for (int k = 0; k < 20; k++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      pos = k % 5;
      exp = (pos == 4) ? 8'hFF : 8'hFE;
`else
      pos = k % 10;
      if (pos < 4) exp = 8'hFE;
      else if (pos == 4 || pos == 9) exp = 8'hFF;
      else exp = 8'h7F;
`endif
      checks++;
      if (bus.Y !== exp) begin
        errors++;
        $display("FAIL two_contenders k%0d: got %h want %h", k, bus.Y, exp);
      end
    end
  endtask

  task automatic test_all();
    logic [7:0] exp;
    logic [7:0] one;
    int idx;
    apply_reset();
    bus.req = 8'hFF;
    for (int k = 0; k < 45; k++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      idx = 0;
`else
      idx = (k / 5) % 8;
`endif
      one = 8'h01 << idx;
      exp = ((k % 5) == 4) ? 8'hFF : ~one;
      checks++;
      if (bus.Y !== exp) begin
        errors++;
        $display("FAIL all_req k%0d: got %h want %h", k, bus.Y, exp);
      end
      checks++;
      if ({bus.G2A, bus.G2B} !== {~bus.G, ~bus.G}) begin
        errors++;
        $display("FAIL enables_together k%0d: got g=%b g2a=%b g2b=%b want g2a=g2b=~g",
                 k, bus.G, bus.G2A, bus.G2B);
      end
    end
  endtask

  task automatic test_sole();
    apply_reset();
    bus.req = 8'h20;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if ({bus.Y, bus.busy} !== {8'hDF, 1'b1}) begin
        errors++;
        $display("FAIL sole_holder k%0d: got y=%h busy=%b want y=df busy=1", k, bus.Y, bus.busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus.req = 8'h01;
    tick();
    bus.req = 8'h02;
    checks++;
    if (bus.Y !== 8'hFE) begin
      errors++;
      $display("FAIL handover_first: got %h want fe", bus.Y);
    end
    tick();
    checks++;
    if ({bus.Y, bus.G} !== {8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL handover_gap: got y=%h g=%b want y=ff g=0", bus.Y, bus.G);
    end
    tick();
    checks++;
    if ({bus.Y, bus.C, bus.B, bus.A} !== {8'hFD, 3'b001}) begin
      errors++;
      $display("FAIL handover_second: got y=%h sel=%b want y=fd sel=001",
               bus.Y, {bus.C, bus.B, bus.A});
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req = 8'h08;
    tick();
    checks++;
    if (bus.Y !== 8'hF7) begin
      errors++;
      $display("FAIL midreset_pre: got %h want f7", bus.Y);
    end
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({bus.Y, bus.busy, bus.G} !== {8'hFF, 2'b00}) begin
      errors++;
      $display("FAIL midreset_applied: got y=%h busy=%b g=%b want y=ff busy=0 g=0",
               bus.Y, bus.busy, bus.G);
    end
    tick();
    checks++;
    if ({bus.Y, bus.C, bus.B, bus.A} !== {8'hFE, 3'b000}) begin
      errors++;
      $display("FAIL midreset_first: got y=%h sel=%b want y=fe sel=000",
               bus.Y, {bus.C, bus.B, bus.A});
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    bus.req = 8'hFF;
    test_reset();
    test_single();
    test_two();
    test_all();
    test_sole();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec138_rr_arbiter.md
Name: dec138_rr_arbiter

Overview:
Round-robin arbiter that shares one 74LS138-style 3-to-8 decoder among 8 requesters. It produces the decoder's select inputs (C,B,A) and enables (G, G2A, G2B), plus the registered active-low decoded grant Y. Sits between request sources, such as chip-select or LED-scan clients, and the shared decoder. Every grant change passes through a one-cycle break-before-make gap.

Parameters:
MAX_HOLD, 4, maximum consecutive grant cycles while any other requester waits; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
req  input  8  request vector, active-high, bit i = requester i
C  output  1  decoder select MSB
B  output  1  decoder select mid bit
A  output  1  decoder select LSB
G  output  1  decoder enable, active-high
G2A  output  1  decoder enable, active-low
G2B  output  1  decoder enable, active-low
Y  output  8  decoded grant, active-low one-hot; 8'hFF when no grant
busy  output  1  high while in GRANT state

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All outputs are registered.
- Reset values:
  - state = IDLE
  - {C,B,A} = 3'b000
  - G = 0, G2A = 1, G2B = 1
  - Y = 8'hFF, busy = 0
  - last-granted pointer = 7, so requester 0 wins first
  - hold_cnt = 0
- States:
  - IDLE: decoder disabled. If |req is true, the winner is loaded and the next state is GRANT. Grant latency is 1 cycle from req sampled.
  - GRANT: G=1, G2A=0, G2B=0, {C,B,A}=winner index, Y = ~(8'h01 << index), busy=1. hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - GAP: decoder disabled for exactly 1 cycle, Y=8'hFF, busy=0, {C,B,A} holds the last index. At the end of GAP: if |req, go to GRANT with a new winner; else go to IDLE.
- Leaving GRANT (go to GAP) when either condition holds:
  - req[index] is sampled 0, or
  - hold_cnt == MAX_HOLD-1 and req has any bit set other than index.
- If MAX_HOLD is reached and no other requester is active, the grant continues indefinitely.
- Winner selection: scan from (last+1) mod 8 upward with wrap-around; the first set bit wins. last is updated to the winner on entry to GRANT. hold_cnt clears on entry to GRANT.
- A requester granted in GRANT, released through GAP and still requesting may win again only if no other bit is set.
- req changes in the same cycle as a state decision: the value sampled at that edge is used; there is no combinational path from req to any output.
- rst_n low in any state: the next edge applies the reset values, regardless of req.
- Enables are never G=1 while G2A or G2B=1. The three enables change together.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority. The lowest set req index always wins, and the last pointer is ignored. MAX_HOLD preemption still applies, but the preempted requester re-wins if it is the lowest index. GAP is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset: rst_n=0 for 2 edges with req=8'hFF -> Y=8'hFF, G=0, G2A=1, G2B=1, {C,B,A}=0, busy=0.
2. Single request: req=8'h04 high at edges 0-2, low from edge 3 -> Y=8'hFB and {C,B,A}=3'b010 at cycles 1-3; cycle 4 GAP with Y=8'hFF; cycle 5 IDLE.
3. Two contenders, MAX_HOLD=4: req=8'h81 held -> Y=8'hFE for 4 cycles, FF for 1, 8'h7F for 4, FF for 1, 8'hFE... repeating.
4. All request: req=8'hFF held -> grant order 0,1,2,...,7,0, each grant 4 cycles separated by 1-cycle gaps. Under ARB_FIXED_PRIO_EN -> index 0 for 4 cycles, gap, index 0 again.
5. Sole long holder: req=8'h20 held 20 cycles -> Y=8'hDF continuously from cycle 1, with no gap despite MAX_HOLD.
6. Reset mid-grant: while index 3 is granted, pulse rst_n=0 for 1 edge with req=8'hFF -> Y=8'hFF next cycle; the first grant after release is index 0.
